// File: rtl/mac_array_pkg.sv
// Shared types and helpers for the tiled MAC array: state encoding,
// lane slicing and saturation limits.
package mac_array_pkg;

   localparam int DW_DEF    = 16;
   localparam int LANES_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_I,
      S_ROW_RD,
      S_ROW_MAC,
      S_ROW_WR,
      S_FIN
   } state_t;

   // Accumulator width: full product, adder-tree growth, one bit for the old O add.
   function automatic int accWidth(input int dw, input int lanes);
      return 2*dw + $clog2(lanes) + 1;
   endfunction

   // Lane j of a packed word sits at [laneHi -: dw]; lane 0 occupies the MSBs.
   function automatic int laneHi(input int dw, input int lanes, input int j);
      return dw*(lanes-j) - 1;
   endfunction

   function automatic longint satMax(input int dw);
      return (longint'(1) <<< (dw-1)) - 1;
   endfunction

   function automatic longint satMin(input int dw);
      return -(longint'(1) <<< (dw-1));
   endfunction

endpackage

// File: rtl/mac_lane.sv
// One output lane of the row MAC: N-masked signed products, summed with an
// optional old-O accumulate, then saturated back to the element width.
module mac_lane
   import mac_array_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int LANES = LANES_DEF
) (
   input  logic [DW*LANES-1:0] i_wRow,
   input  logic [DW*LANES-1:0] i_iCol,
   input  logic [LANES-1:0]    i_nMask,
   input  logic                i_laneEn,
   input  logic                i_acc,
   input  logic [DW-1:0]       i_old,
   output logic [DW-1:0]       o_res
);

   localparam int ACC_W = accWidth(DW, LANES);
   localparam int PW    = 2*DW;
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(satMax(DW));
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(satMin(DW));

   logic signed [PW-1:0]    w_prod [LANES];
   logic signed [ACC_W-1:0] w_sum;

   always_comb begin
      for (int n = 0; n < LANES; n++) begin
         w_prod[n] = PW'($signed(i_wRow[laneHi(DW, LANES, n) -: DW]))
                   * PW'($signed(i_iCol[laneHi(DW, LANES, n) -: DW]));
      end
   end

   // Rows at or beyond N never contribute, whatever the cache or W lane holds.
   always_comb begin
      w_sum = '0;
      for (int n = 0; n < LANES; n++) begin
         if (i_nMask[n]) w_sum = w_sum + ACC_W'(w_prod[n]);
      end
      if (i_acc) w_sum = w_sum + ACC_W'($signed(i_old));
   end

   always_comb begin
      if (!i_laneEn)            o_res = i_acc ? i_old : '0;
      else if (w_sum > SAT_HI)  o_res = SAT_HI[DW-1:0];
      else if (w_sum < SAT_LO)  o_res = SAT_LO[DW-1:0];
      else                      o_res = w_sum[DW-1:0];
   end

endmodule

// File: rtl/mac_array_tiled.sv
// Tiled MAC array controller: loads I into a local cache, then per output row
// reads W (and old O when accumulating), computes all lanes and writes O.
module mac_array_tiled
   import mac_array_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int LANES = LANES_DEF,
   parameter int AW_I  = 3,
   parameter int AW_W  = 3,
   parameter int AW_O  = 4,
   parameter int DIM_W = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_start,
   input  logic [3*DIM_W-1:0]    i_mnt,
   input  logic                  i_acc,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err,
   output logic                  o_en_i,
   output logic [AW_I-1:0]       o_addr_i,
   input  logic [DW*LANES-1:0]   i_rdata_i,
   output logic                  o_en_w,
   output logic [AW_W-1:0]       o_addr_w,
   input  logic [DW*LANES-1:0]   i_rdata_w,
   output logic                  o_en_o,
   output logic                  o_rw_o,
   output logic [AW_O-1:0]       o_addr_o,
   output logic [DW*LANES-1:0]   o_wdata_o,
   input  logic [DW*LANES-1:0]   i_rdata_o
);

   localparam int WW = DW*LANES;

   state_t           r_state;
   logic             r_busy, r_done, r_err;
   logic             r_enI, r_enW, r_enO, r_rwO;
   logic [AW_I-1:0]  r_addrI;
   logic [AW_W-1:0]  r_addrW;
   logic [AW_O-1:0]  r_addrO;
   logic [WW-1:0]    r_wdataO;
   logic [DIM_W-1:0] r_mDim, r_nDim, r_tDim, r_idx, r_row;
   logic             r_acc;
   logic             r_capValid;
   logic [AW_I-1:0]  r_capRow;
   logic [WW-1:0]    r_iRow [LANES];

   logic [DIM_W-1:0] w_mIn, w_nIn, w_tIn;
   logic             w_legal;
   logic [LANES-1:0] w_nMask, w_tMask;
   logic [WW-1:0]    w_resRow;

   assign w_mIn = i_mnt[3*DIM_W-1 -: DIM_W];
   assign w_nIn = i_mnt[2*DIM_W-1 -: DIM_W];
   assign w_tIn = i_mnt[DIM_W-1:0];

   always_comb begin
      w_legal = (w_mIn != '0) && (int'(w_mIn) <= (1 << AW_W))
             && (w_nIn != '0) && (int'(w_nIn) <= LANES)
             && (w_tIn != '0) && (int'(w_tIn) <= LANES);
   end

   always_comb begin
      w_nMask = '0;
      w_tMask = '0;
      for (int j = 0; j < LANES; j++) begin
         w_nMask[j] = (j < int'(r_nDim));
         w_tMask[j] = (j < int'(r_tDim));
      end
   end

   for (genvar t = 0; t < LANES; t++) begin : g_lane
      localparam int HI = laneHi(DW, LANES, t);
      logic [WW-1:0] w_col;

      always_comb begin
         w_col = '0;
         for (int n = 0; n < LANES; n++) begin
            w_col[laneHi(DW, LANES, n) -: DW] = r_iRow[n][HI -: DW];
         end
      end

      mac_lane #(.DW(DW), .LANES(LANES)) u_lane (
         .i_wRow   (i_rdata_w),
         .i_iCol   (w_col),
         .i_nMask  (w_nMask),
         .i_laneEn (w_tMask[t]),
         .i_acc    (r_acc),
         .i_old    (i_rdata_o[HI -: DW]),
         .o_res    (w_resRow[HI -: DW])
      );
   end

   // Read data lags EN_I by one cycle, so the row address is carried along.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_capValid <= 1'b0;
         r_capRow   <= '0;
         for (int r = 0; r < LANES; r++) r_iRow[r] <= '0;
      end else begin
         r_capValid <= r_enI;
         r_capRow   <= r_addrI;
         for (int r = 0; r < LANES; r++) begin
            if (r_capValid && (int'(r_capRow) == r)) r_iRow[r] <= i_rdata_i;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_enI    <= 1'b0;
         r_enW    <= 1'b0;
         r_enO    <= 1'b0;
         r_rwO    <= 1'b0;
         r_addrI  <= '0;
         r_addrW  <= '0;
         r_addrO  <= '0;
         r_wdataO <= '0;
         r_mDim   <= '0;
         r_nDim   <= '0;
         r_tDim   <= '0;
         r_idx    <= '0;
         r_row    <= '0;
         r_acc    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_busy <= 1'b1;
                  if (w_legal) begin
                     r_mDim  <= w_mIn;
                     r_nDim  <= w_nIn;
                     r_tDim  <= w_tIn;
                     r_acc   <= i_acc;
                     r_idx   <= '0;
                     r_row   <= '0;
                     r_enI   <= 1'b1;
                     r_addrI <= '0;
                     r_state <= S_LOAD_I;
                  end else begin
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                     r_state <= S_FIN;
                  end
               end
            end
            S_LOAD_I: begin
               if (r_idx == r_nDim - DIM_W'(1)) begin
                  r_enI   <= 1'b0;
                  r_enW   <= 1'b1;
                  r_addrW <= '0;
                  r_enO   <= r_acc;
                  r_rwO   <= 1'b0;
                  r_addrO <= '0;
                  r_state <= S_ROW_RD;
               end else begin
                  r_idx   <= r_idx + DIM_W'(1);
                  r_addrI <= AW_I'(r_idx + DIM_W'(1));
               end
            end
            S_ROW_RD: begin
               r_enW   <= 1'b0;
               r_enO   <= 1'b0;
               r_state <= S_ROW_MAC;
            end
            S_ROW_MAC: begin
               r_wdataO <= w_resRow;
               r_enO    <= 1'b1;
               r_rwO    <= 1'b1;
               r_addrO  <= AW_O'(r_row);
               r_state  <= S_ROW_WR;
            end
            S_ROW_WR: begin
               r_enO <= 1'b0;
               r_rwO <= 1'b0;
               if (r_row == r_mDim - DIM_W'(1)) begin
                  r_done  <= 1'b1;
                  r_err   <= 1'b0;
                  r_state <= S_FIN;
               end else begin
                  r_row   <= r_row + DIM_W'(1);
                  r_enW   <= 1'b1;
                  r_addrW <= AW_W'(r_row + DIM_W'(1));
                  r_enO   <= r_acc;
                  r_addrO <= AW_O'(r_row + DIM_W'(1));
                  r_state <= S_ROW_RD;
               end
            end
            S_FIN: begin
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_err     = r_err;
   assign o_en_i    = r_enI;
   assign o_addr_i  = r_addrI;
   assign o_en_w    = r_enW;
   assign o_addr_w  = r_addrW;
   assign o_en_o    = r_enO;
   assign o_rw_o    = r_rwO;
   assign o_addr_o  = r_addrO;
   assign o_wdata_o = r_wdataO;

endmodule
